dbus_sram_responder: RTL and testbench

Data-bus responder that terminates the core's dbus request/response handshake on a local synchronous SRAM model. Sits opposite the memory pipeline stage: accepts one `dbus_req_t` at a time, services it after a programmable latency, and returns `dbus_resp_t` with `addr_ok`/`data_ok`. Used as the default data memory in core-level simulation and as a latency-injection target for stall-path verification.

---
 rtl/dbus_sram_responder.sv | 142 ++++++++++++++
 tb/tb_dbus_sram_responder.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/dbus_sram_responder.sv
// Data-bus responder backed by a local 64-bit-wide SRAM array.
// Accepts one request at a time and answers after a fixed, programmable latency.
module dbus_sram_responder #(
    parameter int unsigned LATENCY    = 2,
    parameter int unsigned DEPTH_LOG2 = 12
) (
    input  logic        i_clk,
    input  logic        i_resetn,
    input  logic        i_dreq_valid,
    input  logic [63:0] i_dreq_addr,
    input  logic [2:0]  i_dreq_size,
    input  logic [7:0]  i_dreq_strobe,
    input  logic [63:0] i_dreq_data,
    output logic        o_dresp_addr_ok,
    output logic        o_dresp_data_ok,
    output logic [63:0] o_dresp_data,
    output logic        o_misalign_err,
    output logic [31:0] o_req_count
);
    localparam int unsigned Words  = 2 ** DEPTH_LOG2;
    localparam logic [3:0]  LatCnt = 4'(LATENCY);
    localparam logic [2:0]  Msize2 = 3'd1;
    localparam logic [2:0]  Msize4 = 3'd2;
    localparam logic [2:0]  Msize8 = 3'd3;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e                r_state, w_state_next;
    logic [3:0]            r_cnt, w_cnt_next;
    logic [DEPTH_LOG2-1:0] r_idx, w_idx;
    logic [7:0]            r_strobe, w_strobe;
    logic [63:0]           r_wdata, w_wdata;
    logic [63:0]           r_mem [Words];
    logic [63:0]           r_rdata;
    logic [63:0]           w_word, w_merged;
    logic                  r_misalign;
    logic [31:0]           r_count;
    logic                  w_accept, w_enter_resp, w_misalign;
    logic                  w_unused_addr;

    assign w_unused_addr = ^i_dreq_addr[63:DEPTH_LOG2+3];

    assign w_accept = (r_state == StIdle) && i_dreq_valid;

    // With zero latency the transaction enters RESP straight from IDLE, before
    // the request fields are latched, so the live inputs feed the merge path.
    assign w_idx    = w_accept ? i_dreq_addr[DEPTH_LOG2+2:3] : r_idx;
    assign w_strobe = w_accept ? i_dreq_strobe : r_strobe;
    assign w_wdata  = w_accept ? i_dreq_data : r_wdata;
    assign w_word   = r_mem[w_idx];

    always_comb begin
        w_merged = w_word;
        for (int b = 0; b < 8; b++) begin
            if (w_strobe[b]) begin
                w_merged[8*b +: 8] = w_wdata[8*b +: 8];
            end
        end
    end

    always_comb begin
        w_misalign = 1'b0;
        case (i_dreq_size)
            Msize2:  w_misalign = i_dreq_addr[0];
            Msize4:  w_misalign = |i_dreq_addr[1:0];
            Msize8:  w_misalign = |i_dreq_addr[2:0];
            default: w_misalign = 1'b0;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        unique case (r_state)
            StIdle: begin
                if (i_dreq_valid) begin
                    w_cnt_next = LatCnt;
                    if (LatCnt != 4'd0) begin
                        w_state_next = StWait;
                    end else begin
                        w_state_next = StResp;
                    end
                end
            end
            StWait: begin
                if (r_cnt <= 4'd1) begin
                    w_cnt_next   = 4'd0;
                    w_state_next = StResp;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            StResp:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    assign w_enter_resp = (w_state_next == StResp) && (r_state != StResp);

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state    <= StIdle;
            r_cnt      <= 4'd0;
            r_idx      <= '0;
            r_strobe   <= 8'd0;
            r_wdata    <= 64'd0;
            r_rdata    <= 64'd0;
            r_misalign <= 1'b0;
            r_count    <= 32'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_idx    <= i_dreq_addr[DEPTH_LOG2+2:3];
                r_strobe <= i_dreq_strobe;
                r_wdata  <= i_dreq_data;
                if (w_misalign) begin
                    r_misalign <= 1'b1;
                end
            end
            if (w_enter_resp) begin
                r_rdata <= w_merged;
            end
            if (r_state == StResp) begin
                r_count <= r_count + 32'd1;
            end
        end
    end

    // Array has no reset; a write lands only on the edge that enters RESP.
    always_ff @(posedge i_clk) begin
        if (w_enter_resp && (|w_strobe)) begin
            r_mem[w_idx] <= w_merged;
        end
    end

    assign o_dresp_addr_ok = w_accept;
    assign o_dresp_data_ok = (r_state == StResp);
    assign o_dresp_data    = r_rdata;
    assign o_misalign_err  = r_misalign;
    assign o_req_count     = r_count;
endmodule

// File: tb/tb_dbus_sram_responder.sv
// Directed bench for dbus_sram_responder: one LATENCY=2 instance and one
// LATENCY=0 / DEPTH_LOG2=4 instance sharing clock, reset and request fields.
module tb_dbus_sram_responder;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        valid_a = 1'b0, valid_b = 1'b0;
    logic [63:0] addr = 64'd0;
    logic [2:0]  size = 3'd0;
    logic [7:0]  strobe = 8'd0;
    logic [63:0] wdata = 64'd0;
    logic        aok_a, dok_a, mis_a, aok_b, dok_b, mis_b;
    logic [63:0] data_a, data_b;
    logic [31:0] cnt_a, cnt_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dbus_sram_responder #(.LATENCY(2), .DEPTH_LOG2(12)) u_a (
        .i_clk(clk), .i_resetn(resetn), .i_dreq_valid(valid_a), .i_dreq_addr(addr),
        .i_dreq_size(size), .i_dreq_strobe(strobe), .i_dreq_data(wdata),
        .o_dresp_addr_ok(aok_a), .o_dresp_data_ok(dok_a), .o_dresp_data(data_a),
        .o_misalign_err(mis_a), .o_req_count(cnt_a)
    );

    dbus_sram_responder #(.LATENCY(0), .DEPTH_LOG2(4)) u_b (
        .i_clk(clk), .i_resetn(resetn), .i_dreq_valid(valid_b), .i_dreq_addr(addr),
        .i_dreq_size(size), .i_dreq_strobe(strobe), .i_dreq_data(wdata),
        .o_dresp_addr_ok(aok_b), .o_dresp_data_ok(dok_b), .o_dresp_data(data_b),
        .o_misalign_err(mis_b), .o_req_count(cnt_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One transaction on instance sel (0=A, 1=B); lat = data_ok cycle minus accept cycle.
    task automatic txn(input bit sel, input logic [63:0] a, input logic [2:0] sz,
                       input logic [7:0] st, input logic [63:0] wd,
                       output logic [63:0] rd, output int lat, output int n_aok,
                       output bit mis_acc, output bit mis_next);
        int acc;
        int ok;
        @(posedge clk); #1;
        addr = a; size = sz; strobe = st; wdata = wd;
        if (sel) valid_b = 1'b1; else valid_a = 1'b1;
        acc = -1; ok = -1; n_aok = 0; rd = '0; mis_acc = 1'b0; mis_next = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (acc >= 0 && i == acc + 1) mis_next = sel ? mis_b : mis_a;
            if (sel ? aok_b : aok_a) begin
                n_aok++;
                if (acc < 0) begin
                    acc = i;
                    mis_acc = sel ? mis_b : mis_a;
                end
            end
            if (sel ? dok_b : dok_a) begin
                ok = i;
                rd = sel ? data_b : data_a;
                break;
            end
        end
        lat = (acc >= 0 && ok >= 0) ? ok - acc : -1;
        @(posedge clk); #1;
        valid_a = 1'b0; valid_b = 1'b0;
    endtask

    initial begin
        logic [63:0] rd;
        int lat, n_aok;
        bit m0, m1;
        logic [5:0] aok_v, dok_v;

        // Reset state
        #12;
        check("rst_addr_ok", 64'(aok_a), 64'd0);
        check("rst_data_ok", 64'(dok_a), 64'd0);
        check("rst_data", data_a, 64'd0);
        check("rst_misalign", 64'(mis_a), 64'd0);
        check("rst_count", 64'(cnt_a), 64'd0);
        @(negedge clk); resetn = 1'b1;

        // Full write then read back, LATENCY=2
        txn(1'b0, 64'h80, 3'd3, 8'hFF, 64'h1122334455667788, rd, lat, n_aok, m0, m1);
        check("wr_latency", 64'(lat), 64'd3);
        check("wr_one_addr_ok", 64'(n_aok), 64'd1);
        check("wr_data", rd, 64'h1122334455667788);
        check("wr_pulse_low", 64'(dok_a), 64'd0);
        check("wr_count", 64'(cnt_a), 64'd1);
        txn(1'b0, 64'h80, 3'd3, 8'h00, 64'd0, rd, lat, n_aok, m0, m1);
        check("rd_latency", 64'(lat), 64'd3);
        check("rd_data", rd, 64'h1122334455667788);
        check("rd_count", 64'(cnt_a), 64'd2);

        // Partial (upper half) write
        txn(1'b0, 64'h84, 3'd2, 8'hF0, 64'hAABBCCDD00000000, rd, lat, n_aok, m0, m1);
        check("pw_merged", rd, 64'hAABBCCDD55667788);
        check("pw_no_misalign", 64'(m1), 64'd0);
        txn(1'b0, 64'h80, 3'd3, 8'h00, 64'd0, rd, lat, n_aok, m0, m1);
        check("pw_readback", rd, 64'hAABBCCDD55667788);
        check("pw_count", 64'(cnt_a), 64'd4);

        // Misaligned MSIZE4 read: error appears the cycle after acceptance and sticks
        txn(1'b0, 64'h82, 3'd2, 8'h00, 64'd0, rd, lat, n_aok, m0, m1);
        check("mis_at_accept", 64'(m0), 64'd0);
        check("mis_next_cycle", 64'(m1), 64'd1);
        check("mis_data", rd, 64'hAABBCCDD55667788);
        txn(1'b0, 64'h100, 3'd3, 8'hFF, 64'h0123456789ABCDEF, rd, lat, n_aok, m0, m1);
        check("mis_sticky", 64'(mis_a), 64'd1);
        check("mis_count", 64'(cnt_a), 64'd6);

        // Reset during WAIT of a write to 0x100
        @(posedge clk); #1;
        addr = 64'h100; size = 3'd3; strobe = 8'hFF; wdata = 64'hFFFF_FFFF_FFFF_FFFF;
        valid_a = 1'b1;
        @(negedge clk);
        check("mw_accept", 64'(aok_a), 64'd1);
        @(posedge clk); #1;
        resetn = 1'b0; valid_a = 1'b0;
        #1;
        check("mw_addr_ok", 64'(aok_a), 64'd0);
        check("mw_data_ok", 64'(dok_a), 64'd0);
        check("mw_data", data_a, 64'd0);
        check("mw_misalign", 64'(mis_a), 64'd0);
        check("mw_count", 64'(cnt_a), 64'd0);
        @(negedge clk); resetn = 1'b1;
        txn(1'b0, 64'h100, 3'd3, 8'h00, 64'd0, rd, lat, n_aok, m0, m1);
        check("mw_prior_data", rd, 64'h0123456789ABCDEF);
        check("mw_latency", 64'(lat), 64'd3);
        check("mw_count_after", 64'(cnt_a), 64'd1);

        // LATENCY=0, DEPTH_LOG2=4: aliasing of 0x80 onto 0x0
        txn(1'b1, 64'h0, 3'd3, 8'hFF, 64'hDEAD, rd, lat, n_aok, m0, m1);
        check("b_wr_latency", 64'(lat), 64'd1);
        check("b_wr_data", rd, 64'hDEAD);
        txn(1'b1, 64'h80, 3'd3, 8'h00, 64'd0, rd, lat, n_aok, m0, m1);
        check("b_alias_data", rd, 64'hDEAD);

        // Back-to-back reads with valid held high
        @(posedge clk); #1;
        addr = 64'h80; size = 3'd3; strobe = 8'h00; wdata = 64'd0;
        valid_b = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            aok_v[i] = aok_b;
            dok_v[i] = dok_b;
            if (dok_b) check("b2b_data", data_b, 64'hDEAD);
        end
        @(posedge clk); #1;
        valid_b = 1'b0;
        check("b2b_addr_ok", 64'(aok_v), 64'(6'b010101));
        check("b2b_data_ok", 64'(dok_v), 64'(6'b101010));
        @(negedge clk);
        check("b2b_count", 64'(cnt_b), 64'd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
